// File: rtl/midi_tx.sv
// MIDI OUT serialiser: sends a latched 1-3 byte MIDI message as 8N1 frames, LSB first.
// Message length comes from the status byte; non-status bytes are accepted and dropped.
module midi_tx #(
  parameter int CLK_DIV = 1600
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [23:0] MIDI_MSG,
  input  logic        MIDI_MSG_VALID,
  output logic        MIDI_MSG_READY,
  output logic        MIDI_OUT,
  output logic        MIDI_TX_DONE
);

  // Handshake: a message is taken on the posedge where MIDI_MSG_VALID and
  // MIDI_MSG_READY are both 1; VALID while READY is 0 is ignored and not queued.
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  last_q, last_d;
  logic [23:0] msg_q, msg_d;
  logic        out_q, out_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic [7:0]  cur_byte;

  assign bit_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = msg_q[23:16];
      2'd1:    cur_byte = msg_q[15:8];
      default: cur_byte = msg_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    last_d  = last_q;
    msg_d   = msg_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE && state_q != S_SKIP) begin
      div_d = bit_end ? '0 : div_q + DW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (MIDI_MSG_VALID && ready_q) begin
          msg_d  = MIDI_MSG;
          div_d  = '0;
          bit_d  = 3'd0;
          byte_d = 2'd0;
          // last_d is the index of the final byte to send
          case (MIDI_MSG[23:20])
            4'hC, 4'hD: last_d = 2'd1;
            4'hF:       last_d = 2'd0;
            default:    last_d = 2'd2;
          endcase
          state_d = MIDI_MSG[23] ? S_START : S_SKIP;
        end
      end
      S_SKIP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later, from a flop.
  always_comb begin
    case (state_q)
      S_START: out_d = 1'b0;
      S_DATA:  out_d = cur_byte[bit_q];
      default: out_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      last_q  <= 2'd0;
      msg_q   <= 24'd0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign MIDI_OUT       = out_q;
  assign MIDI_MSG_READY = ready_q;
  assign MIDI_TX_DONE   = done_q;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx with CLK_DIV=16: checks line waveform, DONE/READY timing,
// message lengths, back-to-back acceptance and asynchronous reset.
module tb_midi_tx;
  localparam int CLK_DIV = 16;
  localparam int BT      = 10 * CLK_DIV;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [23:0] MIDI_MSG;
  logic        MIDI_MSG_VALID;
  logic        MIDI_MSG_READY;
  logic        MIDI_OUT;
  logic        MIDI_TX_DONE;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];

  midi_tx #(.CLK_DIV(CLK_DIV)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .MIDI_MSG       (MIDI_MSG),
    .MIDI_MSG_VALID (MIDI_MSG_VALID),
    .MIDI_MSG_READY (MIDI_MSG_READY),
    .MIDI_OUT       (MIDI_OUT),
    .MIDI_TX_DONE   (MIDI_TX_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents msg so it is accepted on the next posedge; returns at the negedge after accept.
  task automatic offer(input logic [23:0] msg, input bit hold);
    @(negedge CLK);
    MIDI_MSG       = msg;
    MIDI_MSG_VALID = 1'b1;
    @(negedge CLK);
    if (!hold) MIDI_MSG_VALID = 1'b0;
  endtask

  // Called at the negedge after accept (cycle 0); checks every cycle through DONE.
  task automatic watch(input int nb, input bit poke, input string tag);
    int         bad_line  = 0;
    int         bad_done  = 0;
    int         bad_ready = 0;
    logic [7:0] b[3];
    logic       e_out;
    int         idx, bi, pos;
    for (int i = 0; i < 3; i++) b[i] = (i < nb) ? exp_q.pop_front() : 8'h00;
    for (int n = 0; n <= nb * BT; n++) begin
      if (n > 0) @(negedge CLK);
      if (poke && n == BT / 2) begin
        MIDI_MSG       = 24'hC12233;
        MIDI_MSG_VALID = 1'b1;
      end
      if (poke && n == BT / 2 + 1) MIDI_MSG_VALID = 1'b0;
      if (n == 0) e_out = 1'b1;
      else begin
        idx = n - 1;
        bi  = idx / BT;
        pos = (idx % BT) / CLK_DIV;
        if (pos == 0)      e_out = 1'b0;
        else if (pos == 9) e_out = 1'b1;
        else               e_out = b[bi][pos-1];
      end
      if (MIDI_OUT !== e_out) bad_line++;
      if (MIDI_TX_DONE !== (n == nb * BT)) bad_done++;
      if (MIDI_MSG_READY !== (n == nb * BT)) bad_ready++;
    end
    chk({tag, "_line_bad_cycles"}, bad_line, 0);
    chk({tag, "_done_bad_cycles"}, bad_done, 0);
    chk({tag, "_ready_bad_cycles"}, bad_ready, 0);
  endtask

  initial begin
    RST_N          = 1'b0;
    MIDI_MSG       = 24'd0;
    MIDI_MSG_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_out", MIDI_OUT, 1);
    chk("rst_ready", MIDI_MSG_READY, 1);
    chk("rst_done", MIDI_TX_DONE, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_out", MIDI_OUT, 1);

    // Note-on, 3 bytes
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    offer(24'h903C64, 1'b0);
    watch(3, 1'b0, "t1");
    @(negedge CLK);
    chk("t1_done_once", MIDI_TX_DONE, 0);
    chk("t1_ready_after", MIDI_MSG_READY, 1);

    // Program change, 2 bytes, with an ignored VALID pulse mid-frame
    exp_q.push_back(8'hC0); exp_q.push_back(8'h05);
    offer(24'hC005FF, 1'b0);
    watch(2, 1'b1, "t2");

    // Real-time, 1 byte
    exp_q.push_back(8'hF8);
    offer(24'hF81234, 1'b0);
    watch(1, 1'b0, "t3");

    // Non-status byte: nothing on the line, DONE next cycle
    offer(24'h123456, 1'b0);
    chk("bad_ready_c0", MIDI_MSG_READY, 0);
    chk("bad_done_c0", MIDI_TX_DONE, 0);
    chk("bad_out_c0", MIDI_OUT, 1);
    @(negedge CLK);
    chk("bad_done_c1", MIDI_TX_DONE, 1);
    chk("bad_ready_c1", MIDI_MSG_READY, 1);
    chk("bad_out_c1", MIDI_OUT, 1);
    @(negedge CLK);
    chk("bad_done_c2", MIDI_TX_DONE, 0);
    chk("bad_out_c2", MIDI_OUT, 1);

    // Back-to-back: VALID held, second message offered while busy
    exp_q.push_back(8'h80); exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
    exp_q.push_back(8'hB0); exp_q.push_back(8'h7B); exp_q.push_back(8'h00);
    offer(24'h803C00, 1'b1);
    MIDI_MSG = 24'hB07B00;
    watch(3, 1'b0, "t4a");
    @(negedge CLK);
    MIDI_MSG_VALID = 1'b0;
    watch(3, 1'b1, "t4b");

    // Reset during data bit 3 of the second byte
    offer(24'h903C64, 1'b0);
    repeat (230) @(negedge CLK);
    chk("t5_ready_busy", MIDI_MSG_READY, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_async_out", MIDI_OUT, 1);
    chk("t5_async_ready", MIDI_MSG_READY, 1);
    chk("t5_async_done", MIDI_TX_DONE, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("t5_idle_out", MIDI_OUT, 1);
    chk("t5_idle_ready", MIDI_MSG_READY, 1);

    // Reset during a start bit must force the line high at once
    offer(24'hF80000, 1'b0);
    repeat (3) @(negedge CLK);
    chk("t5_start_low", MIDI_OUT, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_async_out2", MIDI_OUT, 1);
    chk("t5_async_ready2", MIDI_MSG_READY, 1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    offer(24'h903C64, 1'b0);
    watch(3, 1'b0, "t5_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
